// File: rtl/mvu_job_ctrl.sv
// rtl/mvu_job_ctrl.sv - matrix-vector unit job sequencer (bit-plane read loop, drain, result write)
// Optional stall counter enabled by defining MVU_JOB_CTRL_PERF_EN.
module mvu_job_ctrl #(
  parameter int BWBANKA = 9,
  parameter int BDBANKA = 14,
  parameter int LAT     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [3:0]         cfg_wprec,
  input  logic [3:0]         cfg_iprec,
  input  logic [9:0]         cfg_nvec,
  input  logic [BWBANKA-1:0] cfg_wbase,
  input  logic [BDBANKA-1:0] cfg_ibase,
  input  logic [BDBANKA-1:0] cfg_obase,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr,
  output logic [15:0]        perf_stall
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         wprec_q, wprec_d, iprec_q, iprec_d;
  logic [9:0]         nvec_q, nvec_d, vec_q, vec_d;
  logic [BWBANKA-1:0] wbase_q, wbase_d;
  logic [BDBANKA-1:0] obase_q, obase_d, iptr_q, iptr_d;
  logic [3:0]         wb_q, wb_d, ib_q, ib_d;
  logic [2:0]         drain_q, drain_d;
  logic [LAT-1:0]     clr_pipe_q, clr_pipe_d, sh_pipe_q, sh_pipe_d;
  logic               step_clr, step_sh, accept_start;

  always_comb begin
    state_d      = state_q;
    wprec_d      = wprec_q;
    iprec_d      = iprec_q;
    nvec_d       = nvec_q;
    wbase_d      = wbase_q;
    obase_d      = obase_q;
    iptr_d       = iptr_q;
    wb_d         = wb_q;
    ib_d         = ib_q;
    vec_d        = vec_q;
    drain_d      = drain_q;
    step_clr     = 1'b0;
    step_sh      = 1'b0;
    accept_start = 1'b0;
    done         = 1'b0;
    rdd_en       = 1'b0;
    wrd_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          wprec_d = cfg_wprec;
          iprec_d = cfg_iprec;
          nvec_d  = cfg_nvec;
          wbase_d = cfg_wbase;
          obase_d = cfg_obase;
          iptr_d  = cfg_ibase;
          wb_d    = 4'd0;
          ib_d    = 4'd0;
          vec_d   = 10'd0;
          state_d = (cfg_nvec == 10'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        rdd_en = 1'b1;
        if (rdd_grnt) begin
          step_clr = (wb_q == 4'd0) && (ib_q == 4'd0);
          step_sh  = !step_clr;
          // wb is the inner loop; each wrap moves to the next input plane
          if (wb_q == wprec_q - 4'd1) begin
            wb_d   = 4'd0;
            iptr_d = iptr_q + 1'b1;
            if (ib_q == iprec_q - 4'd1) begin
              ib_d    = 4'd0;
              drain_d = 3'd0;
              state_d = S_DRAIN;
            end else begin
              ib_d = ib_q + 4'd1;
            end
          end else begin
            wb_d = wb_q + 4'd1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(LAT - 1)) state_d = S_WRITE;
        else drain_d = drain_q + 3'd1;
      end
      S_WRITE: begin
        wrd_en = 1'b1;
        if (wrd_grnt) begin
          vec_d   = vec_q + 10'd1;
          wb_d    = 4'd0;
          ib_d    = 4'd0;
          state_d = (vec_q + 10'd1 == nvec_q) ? S_DONE : S_RUN;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    clr_pipe_d    = clr_pipe_q;
    sh_pipe_d     = sh_pipe_q;
    clr_pipe_d[0] = step_clr;
    sh_pipe_d[0]  = step_sh;
    for (int i = 1; i < LAT; i++) begin
      clr_pipe_d[i] = clr_pipe_q[i-1];
      sh_pipe_d[i]  = sh_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wprec_q    <= '0;
      iprec_q    <= '0;
      nvec_q     <= '0;
      wbase_q    <= '0;
      obase_q    <= '0;
      iptr_q     <= '0;
      wb_q       <= '0;
      ib_q       <= '0;
      vec_q      <= '0;
      drain_q    <= '0;
      clr_pipe_q <= '0;
      sh_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      wprec_q    <= wprec_d;
      iprec_q    <= iprec_d;
      nvec_q     <= nvec_d;
      wbase_q    <= wbase_d;
      obase_q    <= obase_d;
      iptr_q     <= iptr_d;
      wb_q       <= wb_d;
      ib_q       <= ib_d;
      vec_q      <= vec_d;
      drain_q    <= drain_d;
      clr_pipe_q <= clr_pipe_d;
      sh_pipe_q  <= sh_pipe_d;
    end
  end

  // addresses are forced to zero outside their phase so reset/idle outputs read 0
  assign busy     = (state_q != S_IDLE);
  assign rdw_addr = (state_q == S_RUN) ? wbase_q + BWBANKA'(wb_q) : '0;
  assign rdd_addr = (state_q == S_RUN) ? iptr_q : '0;
  assign wrd_addr = (state_q == S_WRITE) ? obase_q + BDBANKA'(vec_q) : '0;
  assign acc_clr  = clr_pipe_q[LAT-1];
  assign acc_sh   = sh_pipe_q[LAT-1];

`ifdef MVU_JOB_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept_start) stall_d = 16'd0;
    else if (((rdd_en & ~rdd_grnt) | (wrd_en & ~wrd_grnt)) && stall_q != 16'hffff)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign perf_stall = stall_q;
`else
  assign perf_stall = 16'd0;
`endif

endmodule
